// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter serialising four requesters onto a 4x4-bit register file.
// Each grant runs IDLE -> ACCESS (file port driven) -> ACK (one-hot completion pulse).
module rf_access_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_we,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [3:0]  ack,
  output logic [3:0]  rdata,
  output logic        busy,
  output logic        rf_we,
  output logic [1:0]  rf_waddr,
  output logic [3:0]  rf_wdata,
  output logic [1:0]  rf_rsel,
  input  logic [3:0]  rf_rdata
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned PTR_W  = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  last_grant_q, last_grant_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]  ack_q, ack_d;

  logic [PTR_W-1:0]  pick;
  logic [PTR_W-1:0]  cand;
  logic              pick_vld;

  // Rotating priority: scan upward from the requester after the last grant.
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = last_grant_q + PTR_W'(i);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          op_d    = req_we[pick];
          addr_d  = req_addr[{pick, 1'b0} +: ADDR_W];
          wdata_d = req_wdata[{pick, 2'b00} +: DATA_W];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!op_q) begin
          rdata_d = rf_rdata;
        end
        ack_d   = N_REQ'(1) << grant_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PTR_W'(N_REQ - 1);
      grant_q      <= '0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
    end
  end

  // Reset gates the write combinationally so a reset landing in ACCESS never writes.
  assign rf_we    = (state_q == ST_ACCESS) & op_q & ~reset;
  assign rf_waddr = addr_q;
  assign rf_rsel  = addr_q;
  assign rf_wdata = wdata_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Self-checking bench for rf_access_arbiter with a behavioural register file
// and a queue of expected completions.
module tb_rf_access_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  ack;
  logic [3:0]  rdata;
  logic        busy;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [3:0]  rf_wdata;
  logic [1:0]  rf_rsel;
  logic [3:0]  rf_rdata;

  logic [3:0]  rf_mem [4];
  logic        mem_load;

  int n_cmp = 0;
  int n_bad = 0;
  int waited;
  logic [3:0] seen;
  logic       busy_seen;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] rdata;
    logic       chk_rd;
  } exp_t;
  exp_t exp_q[$];
  exp_t ex;

  rf_access_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_rsel   (rf_rsel),
    .rf_rdata  (rf_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: combinational read mux, clocked write port.
  assign rf_rdata = rf_mem[rf_rsel];
  always @(posedge clk) begin
    if (mem_load) begin
      rf_mem[0] <= 4'h0;
      rf_mem[1] <= 4'h0;
      rf_mem[2] <= 4'h0;
      rf_mem[3] <= 4'h5;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  task automatic test_reset();
    reset = 1'b1; mem_load = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_cmp++; if (rdata !== 4'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (rf_rsel !== 2'b00) begin n_bad++; $display("FAIL reset_rsel: got %b want 00", rf_rsel); end
    reset = 1'b0; mem_load = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    @(negedge clk);
    req = 4'b0010; req_we = 4'b0010; req_addr[3:2] = 2'b10; req_wdata[7:4] = 4'hA;
    exp_q.push_back('{ack: 4'b0010, rdata: 4'h0, chk_rd: 1'b0});
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b1) begin n_bad++; $display("FAIL wr_rf_we: got %b want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 2'd2) begin n_bad++; $display("FAIL wr_waddr: got %0d want 2", rf_waddr); end
    n_cmp++; if (rf_wdata !== 4'hA) begin n_bad++; $display("FAIL wr_wdata: got %h want a", rf_wdata); end
    @(negedge clk);
    ex = exp_q.pop_front();
    n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL wr_ack: got %b want %b", ack, ex.ack); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_ack: got %b want 1", busy); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL wr_we_in_ack: got %b want 0", rf_we); end
    req = '0; req_we = '0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_after: got %b want 0", busy); end
    n_cmp++; if (rf_mem[2] !== 4'hA) begin n_bad++; $display("FAIL wr_mem2: got %h want a", rf_mem[2]); end
  endtask

  task automatic test_read();
    @(negedge clk);
    req = 4'b0100; req_we = 4'b0000; req_addr[5:4] = 2'd3;
    exp_q.push_back('{ack: 4'b0100, rdata: 4'h5, chk_rd: 1'b1});
    @(negedge clk);
    n_cmp++; if (rf_rsel !== 2'd3) begin n_bad++; $display("FAIL rd_rsel: got %0d want 3", rf_rsel); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rd_rf_we: got %b want 0", rf_we); end
    @(negedge clk);
    ex = exp_q.pop_front();
    n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL rd_ack: got %b want %b", ack, ex.ack); end
    n_cmp++; if (rdata !== ex.rdata) begin n_bad++; $display("FAIL rd_rdata: got %h want %h", rdata, ex.rdata); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] ph_req [3];
    int         ph_cnt [3];
    logic [3:0] tab_ack [7];
    logic [3:0] tab_rd  [7];
    int         t;
    ph_req[0] = 4'b1111; ph_cnt[0] = 4;
    ph_req[1] = 4'b0100; ph_cnt[1] = 1;
    ph_req[2] = 4'b1001; ph_cnt[2] = 2;
    tab_ack[0] = 4'b0001; tab_rd[0] = 4'h0;
    tab_ack[1] = 4'b0010; tab_rd[1] = 4'h0;
    tab_ack[2] = 4'b0100; tab_rd[2] = 4'hA;
    tab_ack[3] = 4'b1000; tab_rd[3] = 4'h5;
    tab_ack[4] = 4'b0100; tab_rd[4] = 4'hA;
    tab_ack[5] = 4'b1000; tab_rd[5] = 4'h5;
    tab_ack[6] = 4'b0001; tab_rd[6] = 4'h0;
    reset = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req_we = '0; req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    t = 0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      req = ph_req[p];
      for (int j = 0; j < ph_cnt[p]; j++)
        exp_q.push_back('{ack: tab_ack[t + j], rdata: tab_rd[t + j], chk_rd: 1'b1});
      for (int k = 0; k < ph_cnt[p]; k++) begin
        waited = 0;
        do begin
          @(negedge clk);
          waited++;
        end while (ack === 4'b0000 && waited < 8);
        ex = exp_q.pop_front();
        n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL rr_ack[%0d]: got %b want %b", t + k, ack, ex.ack); end
        n_cmp++; if (rdata !== ex.rdata) begin n_bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", t + k, rdata, ex.rdata); end
        n_cmp++;
        if (waited != ((k == 0) ? 2 : 3)) begin
          n_bad++; $display("FAIL rr_spacing[%0d]: got %0d cycles want %0d", t + k, waited, (k == 0) ? 2 : 3);
        end
        req = req & ~ack;
      end
      t = t + ph_cnt[p];
    end
    req = '0;
  endtask

  task automatic test_reset_access();
    @(negedge clk);
    req = 4'b0001; req_we = 4'b0001; req_addr[1:0] = 2'd1; req_wdata[3:0] = 4'hF;
    @(negedge clk);
    n_cmp++; if (rf_we !== 1'b1) begin n_bad++; $display("FAIL rst_pre_we: got %b want 1", rf_we); end
    reset = 1'b1; req = '0; req_we = '0;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rst_gate_we: got %b want 0", rf_we); end
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    seen = '0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ack;
    end
    n_cmp++; if (seen !== 4'b0000) begin n_bad++; $display("FAIL rst_no_ack: got %b want 0000", seen); end
    n_cmp++; if (rf_mem[1] !== 4'h0) begin n_bad++; $display("FAIL rst_no_write: got %h want 0", rf_mem[1]); end
    req = 4'b1001; req_we = '0; req_addr = {2'd3, 2'd2, 2'd1, 2'd1};
    exp_q.push_back('{ack: 4'b0001, rdata: 4'h0, chk_rd: 1'b1});
    exp_q.push_back('{ack: 4'b1000, rdata: 4'h5, chk_rd: 1'b1});
    repeat (2) @(negedge clk);
    ex = exp_q.pop_front();
    n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL rst_first_ack: got %b want %b", ack, ex.ack); end
    n_cmp++; if (rdata !== ex.rdata) begin n_bad++; $display("FAIL rst_first_rdata: got %h want %h", rdata, ex.rdata); end
    req = 4'b1000;
    repeat (3) @(negedge clk);
    ex = exp_q.pop_front();
    n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL rst_second_ack: got %b want %b", ack, ex.ack); end
    n_cmp++; if (rdata !== ex.rdata) begin n_bad++; $display("FAIL rst_second_rdata: got %h want %h", rdata, ex.rdata); end
    req = '0;
  endtask

  task automatic test_withdraw();
    @(negedge clk);
    req = 4'b0001; req_we = 4'b0001; req_addr[1:0] = 2'd2; req_wdata[3:0] = 4'h7;
    exp_q.push_back('{ack: 4'b0001, rdata: 4'h0, chk_rd: 1'b0});
    @(negedge clk);
    req = '0; req_we = '0; req_addr = 8'hFF; req_wdata = 16'hFFFF;
    n_cmp++; if (rf_we !== 1'b1) begin n_bad++; $display("FAIL wd_rf_we: got %b want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 2'd2) begin n_bad++; $display("FAIL wd_waddr: got %0d want 2", rf_waddr); end
    n_cmp++; if (rf_wdata !== 4'h7) begin n_bad++; $display("FAIL wd_wdata: got %h want 7", rf_wdata); end
    @(negedge clk);
    ex = exp_q.pop_front();
    n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL wd_ack: got %b want %b", ack, ex.ack); end
    seen = '0; busy_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ack;
      busy_seen = busy_seen | busy;
    end
    n_cmp++; if (seen !== 4'b0000) begin n_bad++; $display("FAIL wd_idle_ack: got %b want 0000", seen); end
    n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL wd_idle_busy: got %b want 0", busy_seen); end
    n_cmp++; if (rf_mem[2] !== 4'h7) begin n_bad++; $display("FAIL wd_mem2: got %h want 7", rf_mem[2]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_access();
    test_withdraw();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
